vga_timing: RTL

//  Raster timing generator feeding the playfield/sprite colour stages (background, sprites, mux).

---
 rtl/vga_timing.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// vga_timing -- raster timing generator for the playfield/sprite colour stages.
//
// Divides clk by CLK_DIV into a pixel strobe and scans an H_TOTAL x V_TOTAL
// raster (800x525 by default, 640x480@60). Every output is registered and
// only changes in the clk where pixEn is high.
//
// Ports:
//   clk         in   system clock, single domain
//   reset_n     in   asynchronous active-low reset
//   pixEn       out  one-clk strobe every CLK_DIV clks
//   colPos      out  [9:0] current column, 0..H_TOTAL-1
//   rowPos      out  [9:0] current row,    0..V_TOTAL-1
//   on          out  visible area flag
//   hsync       out  horizontal sync, SYNC_POL level inside its window
//   vsync       out  vertical sync, SYNC_POL level inside its window
//   frameStart  out  one-clk strobe when the scan loads (0,0)
//   frameCount  out  [7:0] frames since reset (only with VGA_FRAME_COUNT_EN)
//
// Build option: define VGA_FRAME_COUNT_EN to add the frameCount port and
// its 8-bit wrapping counter.
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pixEn,
  output logic [9:0] colPos,
  output logic [9:0] rowPos,
  output logic       on,
  output logic       hsync,
  output logic       vsync,
  output logic       frameStart
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frameCount
`endif
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing: CLK_DIV must be in 1..16");
    end
  endgenerate

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          h_wrap, v_wrap;
  logic          on_q, on_d, hs_q, hs_d, vs_q, vs_d;
  logic          pe_q, fs_q, fs_d;

  // With CLK_DIV=1 the divider is a single bit stuck at 0, so tick is always high.
  assign tick  = (div_q == DW'(CLK_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Next raster position; on/hsync/vsync are decoded from it so that they
  // load together with colPos/rowPos and stay coherent with them.
  always_comb begin
    h_wrap = (h_q == 10'(H_TOTAL - 1));
    v_wrap = (v_q == 10'(V_TOTAL - 1));
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    // 11-bit compares keep a 1024 boundary representable.
    on_d = ({1'b0, h_d} < 11'(H_VISIBLE)) && ({1'b0, v_d} < 11'(V_VISIBLE));
    hs_d = (({1'b0, h_d} >= 11'(HS_START)) && ({1'b0, h_d} <= 11'(HS_END))) ? SYNC_POL : ~SYNC_POL;
    vs_d = (({1'b0, v_d} >= 11'(VS_START)) && ({1'b0, v_d} <= 11'(VS_END))) ? SYNC_POL : ~SYNC_POL;
    fs_d = tick && (h_d == 10'd0) && (v_d == 10'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      pe_q  <= 1'b0;
      fs_q  <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      on_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      div_q <= div_d;
      pe_q  <= tick;
      fs_q  <= fs_d;
      if (tick) begin
        h_q  <= h_d;
        v_q  <= v_d;
        on_q <= on_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fc_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  fc_q <= '0;
    else if (fs_d) fc_q <= fc_q + 8'd1;
  end
  assign frameCount = fc_q;
`endif

  assign pixEn      = pe_q;
  assign frameStart = fs_q;
  assign colPos     = h_q;
  assign rowPos     = v_q;
  assign on         = on_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;

endmodule
